// File: rtl/ps2_pkg.sv
// ps2_pkg: shared receiver states, protocol codes, digit table and segment encoder
package ps2_pkg;
  typedef enum logic [1:0] {IDLE, DATA, PARITY, STOP} rx_state_t;
  localparam logic [7:0] BREAK_CODE = 8'hF0;
  localparam logic [7:0] EXT_CODE = 8'hE0;
  // Index i holds the make code of digit i.
  localparam logic [9:0][7:0] DIGIT_CODES = {8'h46, 8'h3E, 8'h3D, 8'h36, 8'h2E, 8'h25, 8'h26, 8'h1E, 8'h16, 8'h45};
  function automatic logic [6:0] seg7(input logic [3:0] d);
    case (d)
      4'd0: seg7 = 7'b1000000;
      4'd1: seg7 = 7'b1111001;
      4'd2: seg7 = 7'b0100100;
      4'd3: seg7 = 7'b0110000;
      4'd4: seg7 = 7'b0011001;
      4'd5: seg7 = 7'b0010010;
      4'd6: seg7 = 7'b0000010;
      4'd7: seg7 = 7'b1111000;
      4'd8: seg7 = 7'b0000000;
      4'd9: seg7 = 7'b0010000;
      default: seg7 = 7'b1111111;
    endcase
  endfunction
  // Returns {hit, digit}.
  function automatic logic [4:0] digit_lookup(input logic [7:0] code);
    digit_lookup = '0;
    for (int i = 0; i < 10; i++)
      if (code == DIGIT_CODES[i]) digit_lookup = {1'b1, 4'(i)};
  endfunction
endpackage

// File: rtl/ps2_rx.sv
// ps2_rx: synchronizes the PS/2 lines, deframes 11-bit frames, checks parity/stop, times out stalls
module ps2_rx
  import ps2_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 10000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       ps2_clk,
  input  logic       ps2_data,
  output logic [7:0] rx_byte,
  output logic       rx_valid
);
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  logic [1:0] kc_s, kd_s;
  logic kc_q, fall, reached, par;
  logic [2:0] bit_cnt;
  logic [TW-1:0] tcnt;
  rx_state_t state, state_n;
  assign fall = kc_q & ~kc_s[1];
  assign reached = tcnt == TW'(TIMEOUT_CYCLES);
  // Synchronizers reset high so release from reset never fakes a falling edge.
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      kc_s <= 2'b11;
      kd_s <= 2'b11;
      kc_q <= 1'b1;
      state <= IDLE;
      bit_cnt <= '0;
      rx_byte <= '0;
      par <= 1'b0;
      tcnt <= '0;
    end else begin
      kc_s <= {kc_s[0], ps2_clk};
      kd_s <= {kd_s[0], ps2_data};
      kc_q <= kc_s[1];
      state <= state_n;
      tcnt <= fall ? '0 : reached ? tcnt : tcnt + 1'b1;
      bit_cnt <= state != DATA ? '0 : fall ? bit_cnt + 1'b1 : bit_cnt;
      if (fall && state == DATA) rx_byte <= {kd_s[1], rx_byte[7:1]};
      if (fall && state == PARITY) par <= kd_s[1];
    end
  always_comb begin
    state_n = state;
    rx_valid = 1'b0;
    if (fall)
      case (state)
        IDLE: state_n = kd_s[1] ? IDLE : DATA;
        DATA: state_n = bit_cnt == 3'd7 ? PARITY : DATA;
        PARITY: state_n = STOP;
        STOP: begin
          state_n = IDLE;
          rx_valid = kd_s[1] & ^{rx_byte, par};
        end
        default: state_n = IDLE;
      endcase
    else if (state != IDLE && reached)
      state_n = IDLE;
  end
endmodule

// File: rtl/ps2_keyboard_display.sv
// ps2_keyboard_display: PS/2 keyboard digit keys shown on one active-low seven-segment digit
module ps2_keyboard_display
  import ps2_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 10000
) (
  input  logic       clk,
  input  logic       reset,
  inout  wire        keyb_clk,
  input  logic       keyb_data,
  output logic [6:0] hex_display
);
  logic [7:0] rx_byte, scan_code;
  logic rx_valid, brk, shown;
  logic [3:0] number;
  logic [4:0] dec;
  assign keyb_clk = 1'bz;
  ps2_rx #(.TIMEOUT_CYCLES(TIMEOUT_CYCLES)) u_rx (
    .clk(clk),
    .reset(reset),
    .ps2_clk(keyb_clk),
    .ps2_data(keyb_data),
    .rx_byte(rx_byte),
    .rx_valid(rx_valid)
  );
  assign dec = digit_lookup(rx_byte);
  // A byte following F0 is a key release: stored, never decoded, and it clears the flag.
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      scan_code <= '0;
      number <= '0;
      shown <= 1'b0;
      brk <= 1'b0;
    end else if (rx_valid) begin
      scan_code <= rx_byte;
      brk <= !brk && rx_byte == BREAK_CODE;
      if (!brk && rx_byte != EXT_CODE && dec[4]) begin
        number <= dec[3:0];
        shown <= 1'b1;
      end
    end
  assign hex_display = shown ? seg7(number) : 7'b1111111;
endmodule

// File: tb/tb_ps2_keyboard_display.sv
// tb_ps2_keyboard_display: directed table, corner sequences and random frames against a reference model
module tb_ps2_keyboard_display;
  localparam int TO = 10000;
  logic clk = 1'b0;
  logic reset = 1'b1;
  logic kclk_drv = 1'b1;
  logic keyb_data = 1'b1;
  wire keyb_clk;
  logic [6:0] hex_display;
  assign keyb_clk = kclk_drv;
  always #5 clk = ~clk;
  ps2_keyboard_display #(.TIMEOUT_CYCLES(TO)) dut (
    .clk(clk),
    .reset(reset),
    .keyb_clk(keyb_clk),
    .keyb_data(keyb_data),
    .hex_display(hex_display)
  );
  int checks = 0;
  int errors = 0;
  logic [6:0] seg_ref [10] = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000, 7'b0011001,
                               7'b0010010, 7'b0000010, 7'b1111000, 7'b0000000, 7'b0010000};
  logic [7:0] dcodes [10] = '{8'h45, 8'h16, 8'h1E, 8'h26, 8'h25, 8'h2E, 8'h36, 8'h3D, 8'h3E, 8'h46};
  int digit_of [256];
  logic [7:0] m_scan;
  logic [3:0] m_num;
  bit m_shown, m_brk;
  typedef struct {
    logic [7:0] code;
    bit bad_par;
    bit bad_stop;
    logic [7:0] scan;
    logic [3:0] num;
    logic [6:0] hex;
  } vec_t;
  vec_t vecs [$];
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask
  task automatic wait_clk(input int n);
    repeat (n) @(negedge clk);
  endtask
  function automatic logic [10:0] mk_frame(input logic [7:0] b, input bit bad_par, input bit bad_stop);
    return {~bad_stop, (~^b) ^ bad_par, b, 1'b0};
  endfunction
  task automatic send_bits(input logic [10:0] frame, input int nbits, input int half);
    for (int i = 0; i < nbits; i++) begin
      keyb_data = frame[i];
      wait_clk(half);
      kclk_drv = 1'b0;
      wait_clk(half);
      kclk_drv = 1'b1;
    end
  endtask
  task automatic model_reset();
    m_scan = '0;
    m_num = '0;
    m_shown = 0;
    m_brk = 0;
  endtask
  task automatic model_byte(input logic [7:0] b, input bit bad_par, input bit bad_stop);
    if (bad_par || bad_stop) return;
    m_scan = b;
    if (m_brk) m_brk = 0;
    else if (b == 8'hF0) m_brk = 1;
    else if (digit_of[b] >= 0) begin
      m_num = 4'(digit_of[b]);
      m_shown = 1;
    end
  endtask
  task automatic send(input logic [7:0] b, input bit bad_par, input bit bad_stop, input int half);
    send_bits(mk_frame(b, bad_par, bad_stop), 11, half);
    model_byte(b, bad_par, bad_stop);
    wait_clk(8);
    keyb_data = 1'b1;
  endtask
  task automatic check_model(input string tag);
    check({tag, " scan"}, 32'(dut.scan_code), 32'(m_scan));
    check({tag, " number"}, 32'(dut.number), 32'(m_num));
    check({tag, " hex"}, 32'(hex_display), 32'(m_shown ? seg_ref[m_num] : 7'h7f));
  endtask
  initial begin
    for (int i = 0; i < 256; i++) digit_of[i] = -1;
    for (int i = 0; i < 10; i++) digit_of[dcodes[i]] = i;
    model_reset();
    vecs.push_back('{8'h16, 1'b0, 1'b0, 8'h16, 4'd1, 7'b1111001});
    vecs.push_back('{8'h1E, 1'b0, 1'b0, 8'h1E, 4'd2, 7'b0100100});
    vecs.push_back('{8'h26, 1'b0, 1'b0, 8'h26, 4'd3, 7'b0110000});
    vecs.push_back('{8'h25, 1'b0, 1'b0, 8'h25, 4'd4, 7'b0011001});
    vecs.push_back('{8'h2E, 1'b0, 1'b0, 8'h2E, 4'd5, 7'b0010010});
    vecs.push_back('{8'h25, 1'b0, 1'b0, 8'h25, 4'd4, 7'b0011001});
    vecs.push_back('{8'hF0, 1'b0, 1'b0, 8'hF0, 4'd4, 7'b0011001});
    vecs.push_back('{8'h25, 1'b0, 1'b0, 8'h25, 4'd4, 7'b0011001});
    vecs.push_back('{8'h2E, 1'b1, 1'b0, 8'h25, 4'd4, 7'b0011001});
    vecs.push_back('{8'h2E, 1'b0, 1'b1, 8'h25, 4'd4, 7'b0011001});
    vecs.push_back('{8'hE0, 1'b0, 1'b0, 8'hE0, 4'd4, 7'b0011001});
    vecs.push_back('{8'h3D, 1'b0, 1'b0, 8'h3D, 4'd7, 7'b1111000});
    vecs.push_back('{8'h36, 1'b0, 1'b0, 8'h36, 4'd6, 7'b0000010});
    vecs.push_back('{8'h3E, 1'b0, 1'b0, 8'h3E, 4'd8, 7'b0000000});
    vecs.push_back('{8'h46, 1'b0, 1'b0, 8'h46, 4'd9, 7'b0010000});
    wait_clk(5);
    reset = 1'b0;
    wait_clk(20);
    check("reset scan", 32'(dut.scan_code), 32'h0);
    check("reset number", 32'(dut.number), 32'h0);
    check("reset hex", 32'(hex_display), 32'h7f);
    foreach (vecs[i]) begin
      send(vecs[i].code, vecs[i].bad_par, vecs[i].bad_stop, 10);
      check($sformatf("vec%0d scan", i), 32'(dut.scan_code), 32'(vecs[i].scan));
      check($sformatf("vec%0d number", i), 32'(dut.number), 32'(vecs[i].num));
      check($sformatf("vec%0d hex", i), 32'(hex_display), 32'(vecs[i].hex));
    end
    send_bits(mk_frame(8'h3D, 1'b0, 1'b0), 5, 10);
    wait_clk(TO + 10);
    send(8'h45, 1'b0, 1'b0, 10);
    check("timeout number", 32'(dut.number), 32'h0);
    check("timeout hex", 32'(hex_display), 32'b1000000);
    check_model("timeout");
    send_bits(mk_frame(8'h16, 1'b0, 1'b0), 5, 10);
    #2 reset = 1'b1;
    #1;
    model_reset();
    check("midreset scan", 32'(dut.scan_code), 32'h0);
    check("midreset number", 32'(dut.number), 32'h0);
    check("midreset hex", 32'(hex_display), 32'h7f);
    wait_clk(3);
    reset = 1'b0;
    wait_clk(5);
    send(8'h46, 1'b0, 1'b0, 10);
    check("postreset scan", 32'(dut.scan_code), 32'h46);
    check("postreset number", 32'(dut.number), 32'h9);
    check("postreset hex", 32'(hex_display), 32'b0010000);
    for (int n = 0; n < 40; n++) begin
      int r;
      logic [7:0] code;
      r = $urandom_range(0, 9);
      code = r < 6 ? dcodes[$urandom_range(0, 9)] : r < 7 ? 8'hF0 : r < 8 ? 8'hE0 : 8'($urandom);
      send(code, $urandom_range(0, 9) == 0, $urandom_range(0, 9) == 0, $urandom_range(4, 15));
      check_model($sformatf("rand%0d", n));
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
